// File: rtl/stage3_fast_nn_sched.sv
// stage3_fast_nn_sched
//
// Sequencing controller for the stage-3 NN fast-compression encoder.
// Accepts a group of up to three NN messages and feeds the present ones to an
// external combinational encoder one at a time, in slot order 1 -> 2 -> 3.
// The block owns the PID1/MC1/MT1 copy-operator field registers. After each
// message is handed downstream they are reloaded from that message, so each
// message is encoded against its predecessor's fields. Every encoder result
// is registered and presented downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       group handshake
//   in_mask                 bit i-1 set = slot i message present
//   in_msg_1..3             slot messages
//   dict_reset              clear field registers (block boundary)
//   enc_message             message presented to the encoder
//   enc_field_PID1/MC1/MT1  current field registers presented to the encoder
//   enc_fast, enc_length    encoder result (combinational from enc_*)
//   out_valid/out_ready     result handshake
//   out_data, out_len       registered encoder result
//   out_slot, out_last      source slot (1..3), last present message of group
//   msg_count               emitted-message counter (wraps)

`timescale 1ns/1ps

module stage3_fast_nn_sched #(
  parameter int MSG_W   = 32,
  parameter int FAST_W  = 344,
  parameter int LEN_W   = 8,
  parameter int PID_W   = 8,
  parameter int MC_W    = 8,
  parameter int MT_W    = 8,
  parameter int PID_LSB = 24,
  parameter int MC_LSB  = 16,
  parameter int MT_LSB  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mask,
  input  logic [MSG_W-1:0]  in_msg_1,
  input  logic [MSG_W-1:0]  in_msg_2,
  input  logic [MSG_W-1:0]  in_msg_3,
  input  logic              dict_reset,
  output logic [MSG_W-1:0]  enc_message,
  output logic [PID_W-1:0]  enc_field_PID1,
  output logic [MC_W-1:0]   enc_field_MC1,
  output logic [MT_W-1:0]   enc_field_MT1,
  input  logic [FAST_W-1:0] enc_fast,
  input  logic [LEN_W-1:0]  enc_length,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FAST_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic [1:0]        out_slot,
  output logic              out_last,
  output logic [15:0]       msg_count
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t state, next_state;

  logic [MSG_W-1:0] cap_msg_1, cap_msg_2, cap_msg_3;
  logic [2:0]       cap_mask;
  logic [1:0]       cur_slot;
  logic [MSG_W-1:0] cur_msg;
  logic [2:0]       slot_bit;
  logic [2:0]       mask_rem;
  logic             is_last;
  logic [PID_W-1:0] field_pid;
  logic [MC_W-1:0]  field_mc;
  logic [MT_W-1:0]  field_mt;

  // Slot number (1..3) of the lowest present message; 0 when none remain.
  function automatic logic [1:0] lowest_slot(input logic [2:0] m);
    if (m[0])      return 2'd1;
    else if (m[1]) return 2'd2;
    else if (m[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  // Select the current slot's message, its mask bit, and whether any
  // later slot is still pending (which decides out_last).
  always_comb begin
    cur_msg  = cap_msg_1;
    slot_bit = 3'b000;
    is_last  = 1'b1;
    case (cur_slot)
      2'd1: begin
        cur_msg  = cap_msg_1;
        slot_bit = 3'b001;
        is_last  = ~|cap_mask[2:1];
      end
      2'd2: begin
        cur_msg  = cap_msg_2;
        slot_bit = 3'b010;
        is_last  = ~cap_mask[2];
      end
      2'd3: begin
        cur_msg  = cap_msg_3;
        slot_bit = 3'b100;
        is_last  = 1'b1;
      end
      default: begin
        cur_msg  = cap_msg_1;
        slot_bit = 3'b000;
        is_last  = 1'b1;
      end
    endcase
  end

  assign mask_rem = cap_mask & ~slot_bit;

  // In IDLE the encoder sees the slot-1 latched message; its result is
  // only sampled in LOAD.
  assign enc_message    = (state == IDLE) ? cap_msg_1 : cur_msg;
  assign enc_field_PID1 = field_pid;
  assign enc_field_MC1  = field_mc;
  assign enc_field_MT1  = field_mt;
  assign in_ready       = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. An empty group is accepted and dropped in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid && (in_mask != 3'b000)) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          next_state = (mask_rem != 3'b000) ? LOAD : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: group capture, result registration, and field update on
  // handshake. dict_reset is applied last so it overrides a coinciding
  // handshake update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_msg_1 <= '0;
      cap_msg_2 <= '0;
      cap_msg_3 <= '0;
      cap_mask  <= 3'b000;
      cur_slot  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_slot  <= 2'd0;
      out_last  <= 1'b0;
      msg_count <= 16'd0;
      field_pid <= '0;
      field_mc  <= '0;
      field_mt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_msg_1 <= in_msg_1;
            cap_msg_2 <= in_msg_2;
            cap_msg_3 <= in_msg_3;
            cap_mask  <= in_mask;
            cur_slot  <= lowest_slot(in_mask);
          end
        end
        LOAD: begin
          out_data  <= enc_fast;
          out_len   <= enc_length;
          out_slot  <= cur_slot;
          out_last  <= is_last;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            field_pid <= cur_msg[PID_LSB +: PID_W];
            field_mc  <= cur_msg[MC_LSB +: MC_W];
            field_mt  <= cur_msg[MT_LSB +: MT_W];
            cap_mask  <= mask_rem;
            cur_slot  <= lowest_slot(mask_rem);
            msg_count <= msg_count + 16'd1;
          end
        end
        default: begin
        end
      endcase
      if (dict_reset) begin
        field_pid <= '0;
        field_mc  <= '0;
        field_mt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stage3_fast_nn_sched.sv
// tb_stage3_fast_nn_sched
//
// Testbench for stage3_fast_nn_sched. Supplies a small stand-in encoder:
// each of PID1/MC1/MT1 that differs from the field register adds one byte
// to a base length of 10, and the top 16 bits form a presence map
// {1, pid_match, mc_match, mt_match, 12'h000}. Expected results come from a
// group-level reference model feeding a scoreboard queue; a monitor pops
// and compares on every output handshake.

`timescale 1ns/1ps

module tb_stage3_fast_nn_sched;

  localparam int MSG_W   = 32;
  localparam int FAST_W  = 344;
  localparam int LEN_W   = 8;
  localparam int PID_LSB = 24;
  localparam int MC_LSB  = 16;
  localparam int MT_LSB  = 8;
  localparam int PAD_W   = FAST_W - 16 - 24 - MSG_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mask;
  logic [MSG_W-1:0]  in_msg_1, in_msg_2, in_msg_3;
  logic              dict_reset;
  logic [MSG_W-1:0]  enc_message;
  logic [7:0]        enc_field_PID1, enc_field_MC1, enc_field_MT1;
  logic [FAST_W-1:0] enc_fast;
  logic [LEN_W-1:0]  enc_length;
  logic              out_valid;
  logic              out_ready;
  logic [FAST_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic [1:0]        out_slot;
  logic              out_last;
  logic [15:0]       msg_count;

  stage3_fast_nn_sched #(
    .MSG_W(MSG_W), .FAST_W(FAST_W), .LEN_W(LEN_W),
    .PID_W(8), .MC_W(8), .MT_W(8),
    .PID_LSB(PID_LSB), .MC_LSB(MC_LSB), .MT_LSB(MT_LSB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_msg_1(in_msg_1), .in_msg_2(in_msg_2), .in_msg_3(in_msg_3),
    .dict_reset(dict_reset),
    .enc_message(enc_message),
    .enc_field_PID1(enc_field_PID1), .enc_field_MC1(enc_field_MC1),
    .enc_field_MT1(enc_field_MT1),
    .enc_fast(enc_fast), .enc_length(enc_length),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_len(out_len), .out_slot(out_slot),
    .out_last(out_last), .msg_count(msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in encoder.
  function automatic logic [LEN_W-1:0] enc_len_f(input logic [MSG_W-1:0] m,
      input logic [7:0] pid, input logic [7:0] mc, input logic [7:0] mt);
    int n;
    n = 10;
    if (m[PID_LSB +: 8] != pid) n++;
    if (m[MC_LSB +: 8] != mc) n++;
    if (m[MT_LSB +: 8] != mt) n++;
    return LEN_W'(n);
  endfunction

  function automatic logic [FAST_W-1:0] enc_fast_f(input logic [MSG_W-1:0] m,
      input logic [7:0] pid, input logic [7:0] mc, input logic [7:0] mt);
    logic [15:0] pmap;
    pmap = {1'b1, m[PID_LSB +: 8] == pid, m[MC_LSB +: 8] == mc,
            m[MT_LSB +: 8] == mt, 12'h000};
    return {pmap, {PAD_W{1'b0}}, pid, mc, mt, m};
  endfunction

  assign enc_fast   = enc_fast_f(enc_message, enc_field_PID1, enc_field_MC1, enc_field_MT1);
  assign enc_length = enc_len_f(enc_message, enc_field_PID1, enc_field_MC1, enc_field_MT1);

  typedef struct {
    logic [FAST_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [1:0]        slot;
    logic              last;
  } exp_t;

  exp_t exp_q[$];

  int vectors;
  int miscompares;
  bit rand_ready;

  // Reference model state: fields as the previous emitted message left them.
  logic [7:0]  m_pid, m_mc, m_mt;
  logic [15:0] m_count;

  task automatic check_output(input string name, input logic [FAST_W-1:0] act,
                              input logic [FAST_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expand a group into expected outputs and advance the model fields.
  // clear_slot names the slot whose handshake coincides with dict_reset.
  task automatic push_group(input logic [2:0] mask, input logic [MSG_W-1:0] m1,
      input logic [MSG_W-1:0] m2, input logic [MSG_W-1:0] m3, input int clear_slot);
    logic [MSG_W-1:0] msgs[3];
    int top;
    exp_t e;
    msgs[0] = m1;
    msgs[1] = m2;
    msgs[2] = m3;
    top = 0;
    for (int s = 1; s <= 3; s++) if (mask[s-1]) top = s;
    for (int s = 1; s <= 3; s++) begin
      if (mask[s-1]) begin
        e.data = enc_fast_f(msgs[s-1], m_pid, m_mc, m_mt);
        e.len  = enc_len_f(msgs[s-1], m_pid, m_mc, m_mt);
        e.slot = 2'(s);
        e.last = (s == top);
        exp_q.push_back(e);
        m_pid = msgs[s-1][PID_LSB +: 8];
        m_mc  = msgs[s-1][MC_LSB +: 8];
        m_mt  = msgs[s-1][MT_LSB +: 8];
        if (s == clear_slot) begin
          m_pid = 8'h00;
          m_mc  = 8'h00;
          m_mt  = 8'h00;
        end
        m_count = m_count + 16'd1;
      end
    end
  endtask

  function automatic logic [MSG_W-1:0] make_msg(input logic [7:0] pid,
      input logic [7:0] mc, input logic [7:0] mt);
    return {pid, mc, mt, 8'($urandom)};
  endfunction

  // Called in the posedge+1 phase; returns one step after the accept edge.
  task automatic apply_stimulus(input logic [2:0] mask, input logic [MSG_W-1:0] m1,
      input logic [MSG_W-1:0] m2, input logic [MSG_W-1:0] m3, input int clear_slot);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check_output("in_ready wait", FAST_W'(in_ready), FAST_W'(1));
    push_group(mask, m1, m2, m3, clear_slot);
    in_valid = 1'b1;
    in_mask  = mask;
    in_msg_1 = m1;
    in_msg_2 = m2;
    in_msg_3 = m3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mask  = 3'($urandom);
    in_msg_1 = $urandom;
    in_msg_2 = $urandom;
    in_msg_3 = $urandom;
  endtask

  task automatic wait_valid(input string what);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check_output(what, FAST_W'(out_valid), FAST_W'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || !in_ready)
      check_output("drain timeout", FAST_W'(exp_q.size()), FAST_W'(0));
  endtask

  task automatic check_fields(input string what, input logic [7:0] pid,
                              input logic [7:0] mc, input logic [7:0] mt);
    check_output({what, " PID1"}, FAST_W'(enc_field_PID1), FAST_W'(pid));
    check_output({what, " MC1"}, FAST_W'(enc_field_MC1), FAST_W'(mc));
    check_output({what, " MT1"}, FAST_W'(enc_field_MT1), FAST_W'(mt));
  endtask

  // Random downstream readiness when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks that a stalled
  // output holds steady.
  initial begin
    exp_t e;
    bit stalled;
    logic [FAST_W-1:0] h_data;
    logic [LEN_W-1:0]  h_len;
    logic [1:0]        h_slot;
    logic              h_last;
    logic [15:0]       hs_count;
    stalled  = 1'b0;
    hs_count = 16'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled  = 1'b0;
        hs_count = 16'd0;
      end else begin
        if (stalled) begin
          check_output("hold valid", FAST_W'(out_valid), FAST_W'(1));
          check_output("hold data", out_data, h_data);
          check_output("hold len", FAST_W'(out_len), FAST_W'(h_len));
          check_output("hold slot", FAST_W'(out_slot), FAST_W'(h_slot));
          check_output("hold last", FAST_W'(out_last), FAST_W'(h_last));
        end
        if (out_valid && out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected output: got slot %0d, expected none", out_slot);
          end else begin
            e = exp_q.pop_front();
            check_output("out_data", out_data, e.data);
            check_output("out_len", FAST_W'(out_len), FAST_W'(e.len));
            check_output("out_slot", FAST_W'(out_slot), FAST_W'(e.slot));
            check_output("out_last", FAST_W'(out_last), FAST_W'(e.last));
            check_output("msg_count", FAST_W'(msg_count), FAST_W'(hs_count));
            hs_count = hs_count + 16'd1;
          end
        end else if (out_valid) begin
          stalled = 1'b1;
          h_data  = out_data;
          h_len   = out_len;
          h_slot  = out_slot;
          h_last  = out_last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] sp, sm, st;
    logic [2:0] mask;
    vectors     = 0;
    miscompares = 0;
    rand_ready  = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_mask     = 3'b000;
    in_msg_1    = '0;
    in_msg_2    = '0;
    in_msg_3    = '0;
    dict_reset  = 1'b0;
    out_ready   = 1'b0;
    m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00;
    m_count = 16'd0;

    // Reset state.
    @(posedge clk); #1;
    check_output("reset in_ready", FAST_W'(in_ready), FAST_W'(1));
    check_output("reset out_valid", FAST_W'(out_valid), FAST_W'(0));
    check_output("reset out_data", out_data, '0);
    check_output("reset out_len", FAST_W'(out_len), FAST_W'(0));
    check_output("reset out_slot", FAST_W'(out_slot), FAST_W'(0));
    check_output("reset out_last", FAST_W'(out_last), FAST_W'(0));
    check_output("reset msg_count", FAST_W'(msg_count), FAST_W'(0));
    check_fields("reset", 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full group, identical fields, continuous ready; latency pattern.
    dict_reset = 1'b1;
    @(posedge clk); #1;
    dict_reset = 1'b0;
    out_ready  = 1'b1;
    apply_stimulus(3'b111, make_msg(8'h05, 8'h10, 8'h20), make_msg(8'h05, 8'h10, 8'h20),
                   make_msg(8'h05, 8'h10, 8'h20), 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_output($sformatf("valid at T+%0d", k + 1 - 1 + 1 - 1), FAST_W'(out_valid),
                   FAST_W'((k % 2) == 0));
    end
    @(posedge clk); #1;
    check_output("in_ready after group", FAST_W'(in_ready), FAST_W'(1));
    check_output("msg_count after group", FAST_W'(msg_count), FAST_W'(m_count));

    // Sparse mask: slot 3 encoded against slot 1's fields.
    apply_stimulus(3'b101, make_msg(8'h11, 8'h22, 8'h33), make_msg(8'h44, 8'h55, 8'h66),
                   make_msg(8'h11, 8'h29, 8'h33), 0);
    wait_drain();

    // Empty group is dropped.
    apply_stimulus(3'b000, $urandom, $urandom, $urandom, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("empty out_valid", FAST_W'(out_valid), FAST_W'(0));
      check_output("empty in_ready", FAST_W'(in_ready), FAST_W'(1));
    end
    check_output("empty msg_count", FAST_W'(msg_count), FAST_W'(m_count));
    @(posedge clk); #1;

    // Backpressure for 5 cycles on slot 1.
    out_ready = 1'b0;
    sp = m_pid; sm = m_mc; st = m_mt;
    apply_stimulus(3'b111, make_msg(8'h01, 8'h02, 8'h03), make_msg(8'h01, 8'h07, 8'h03),
                   make_msg(8'h09, 8'h07, 8'h03), 0);
    wait_valid("stall valid timeout");
    repeat (5) @(negedge clk);
    check_fields("stall", sp, sm, st);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_output("release load cycle", FAST_W'(out_valid), FAST_W'(0));
    @(negedge clk);
    check_output("release next valid", FAST_W'(out_valid), FAST_W'(1));
    check_output("release next slot", FAST_W'(out_slot), FAST_W'(2));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // dict_reset coinciding with the slot-2 handshake.
    out_ready = 1'b0;
    apply_stimulus(3'b111, make_msg(8'h31, 8'h32, 8'h33), make_msg(8'h41, 8'h42, 8'h43),
                   make_msg(8'(($urandom_range(1, 255))), 8'($urandom_range(1, 255)),
                            8'($urandom_range(1, 255))), 2);
    wait_valid("slot1 valid timeout");
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid("slot2 valid timeout");
    @(posedge clk); #1;
    out_ready  = 1'b1;
    dict_reset = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    dict_reset = 1'b0;
    @(negedge clk);
    check_fields("clear wins", 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset asserted during slot-2 HOLD.
    out_ready = 1'b0;
    apply_stimulus(3'b111, make_msg(8'h51, 8'h52, 8'h53), make_msg(8'h61, 8'h62, 8'h63),
                   make_msg(8'h71, 8'h72, 8'h73), 0);
    wait_valid("slot1 valid timeout");
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid("slot2 valid timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset out_valid", FAST_W'(out_valid), FAST_W'(0));
    check_output("midreset in_ready", FAST_W'(in_ready), FAST_W'(1));
    check_output("midreset msg_count", FAST_W'(msg_count), FAST_W'(0));
    check_fields("midreset", 8'h00, 8'h00, 8'h00);
    exp_q.delete();
    m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00;
    m_count = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(3'b111, make_msg(8'h51, 8'h52, 8'h53), make_msg(8'h51, 8'h62, 8'h53),
                   make_msg(8'h71, 8'h62, 8'h53), 0);
    wait_drain();

    // Randomized groups with random backpressure and occasional block boundaries.
    rand_ready = 1'b1;
    for (int g = 0; g < 40; g++) begin
      if ($urandom_range(0, 5) == 0) begin
        wait_drain();
        dict_reset = 1'b1;
        @(posedge clk); #1;
        dict_reset = 1'b0;
        m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00;
      end
      mask = 3'($urandom_range(0, 7));
      apply_stimulus(mask,
        make_msg(8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))),
        make_msg(8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))),
        make_msg(8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))),
        0);
    end
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    check_output("final msg_count", FAST_W'(msg_count), FAST_W'(m_count));
    check_output("final queue empty", FAST_W'(exp_q.size()), FAST_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage3_fast_nn_sched.md
Name: stage3_fast_nn_sched

Overview:
- Sequencing controller for the stage-3 NN fast-compression encoder.
- Accepts a group of up to three NN messages and feeds them to the encoder one slot at a time, in slot order 1→2→3.
- Owns the PID1/MC1/MT1 copy-operator field registers. After each emitted message it updates them from that message, so every message is compared against its predecessor's fields rather than a stale group-wide value.
- Registers each encoder result and hands it downstream over a valid/ready handshake.

Parameters:
MSG_W, `MAX_MESSAGE_BITS, raw message width
FAST_W, `fast_message_bits, encoded fast message width (344)
LEN_W, `fast_length_bits, encoded length width in bytes (8)
PID_W, `field_PID1_bits, PID1 field width (8)
MC_W, `field_MC1_bits, MC1 field width (8)
MT_W, `field_MT1_bits, MT1 field width (8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  group valid
in_ready  out  1  group accepted when in_valid&in_ready
in_mask  in  3  bit i-1 = slot i message present
in_msg_1/2/3  in  MSG_W  slot messages
dict_reset  in  1  clear field registers (block boundary)
enc_message  out  MSG_W  message driven to encoder
enc_field_PID1/MC1/MT1  out  PID_W/MC_W/MT_W  current field registers to encoder
enc_fast  in  FAST_W  encoder result (combinational from enc_*)
enc_length  in  LEN_W  encoder length, 10..13
out_valid  out  1  encoded message valid
out_ready  in  1  downstream accept
out_data  out  FAST_W  registered enc_fast
out_len  out  LEN_W  registered enc_length
out_slot  out  2  source slot, 1..3
out_last  out  1  last present message of the group
msg_count  out  16  emitted-message counter

Behaviour:
- Reset values (async on rst_n low):
  - state IDLE; in_ready=1; out_valid=0; out_data=0; out_len=0; out_slot=0; out_last=0; msg_count=0.
  - Field registers = 0; captured messages/mask = 0.
  - Applies mid-group: any in-flight group is discarded.
- States: IDLE, LOAD, HOLD.
- IDLE:
  - in_ready=1.
  - On accept: latch in_msg_1..3 and in_mask.
  - in_mask==0 → group dropped, stay IDLE.
  - Otherwise slot = lowest set bit, go to LOAD.
- LOAD (1 cycle):
  - in_ready=0; enc_message = captured message of the current slot.
  - Capture enc_fast→out_data, enc_length→out_len, slot→out_slot.
  - out_last=1 iff no higher mask bit is set.
  - out_valid←1; go to HOLD.
- HOLD:
  - out_valid=1 and out_data/out_len/out_slot/out_last stable until out_valid&out_ready.
  - On handshake:
    - out_valid←0.
    - Field registers ← current message slices [`PID1_b:`PID1_e], [`MC1_b:`MC1_e], [`MT1_b:`MT1_e].
    - Clear the slot's mask bit; msg_count+1, wrapping 0xFFFF→0.
    - Remaining mask≠0 → next lowest slot, LOAD. Else → IDLE.
- Latency and throughput:
  - Accept at cycle T → out_valid at T+2; consecutive messages ≥2 cycles apart.
  - in_ready returns high the cycle after the last handshake.
- enc_message in IDLE = slot-1 latched message. Encoder outputs are ignored outside LOAD.
- dict_reset (synchronous, any state):
  - Field registers ← 0 next edge.
  - Coinciding with a HOLD handshake update: clear wins.
  - Does not abort the group. A message already captured in HOLD keeps its encoding.
- out_ready high while out_valid low has no effect.
- Skipped slots (mask bit 0) never drive the encoder or touch the field registers.

Test Plan:
1. Reset, dict_reset, group mask=3'b111, all three messages with PID1=0x05, MC1=0x10, MT1=0x20, out_ready=1:
   - slot1 out_len=0x0D, out_data[FAST_W-1-:16]=16'h8000.
   - slots 2 and 3 out_len=0x0A, pmap 16'hF000.
   - out_last only on slot 3; msg_count=3; out_valid at T+2, T+4, T+6.
2. mask=3'b101: only slots 1 and 3 emitted, out_slot=1 then 3; slot 3 compared against slot-1 fields; out_last on slot 3.
3. mask=3'b000 → no out_valid, in_ready stays 1; msg_count unchanged.
4. Backpressure, out_ready=0 for 5 cycles in HOLD:
   - out_data/out_len/out_slot stable, no field update.
   - Release → next slot's LOAD follows the next cycle.
5. dict_reset pulsed during the slot-2 HOLD handshake:
   - Field regs read 0 at slot-3 LOAD.
   - Slot 3 with non-zero PID1/MC1/MT1 → out_len=0x0D.
6. rst_n low mid-group (during slot-2 HOLD):
   - out_valid=0 immediately; IDLE, in_ready=1 after release.
   - Fields and msg_count = 0; a new group encodes from cleared fields.
